sched_queue_domain: RTL and testbench

Parametrised multi-queue scheduling domain that replaces the single-mode-per-build domain. It steers incoming packets into per-queue FIFOs using an ID field. It picks one eligible queue per output slot using a runtime-selectable policy: round-robin, fixed priority, or budget-regulated fixed priority. The chosen packet drives a registered valid/ready output toward the serializer. Backpressure is per queue, so a full queue stalls only traffic targeting it.

---
 rtl/sched_queue_domain.sv | 186 ++++++++++++++++++
 tb/tb_sched_queue_domain.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_queue_domain.sv
// Multi-queue scheduling domain: ID-steered per-queue FIFOs, a runtime-selectable
// round-robin / fixed-priority / budget-regulated arbiter and one registered output slot.
module sched_queue_domain #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int DATA_SIZE        = 64,
   parameter int QUEUE_LENGTH     = 16,
   parameter int ID_WIDTH         = 16,
   parameter int ID_OFFSET        = 5,
   parameter int PRIORITY_SIZE    = 4,
   parameter int REGISTER_SIZE    = 32,
   localparam int QW = $clog2(NUMBER_OF_QUEUES)
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [DATA_SIZE-1:0]                        in_packet,
   input  logic                                        in_valid,
   input  logic [ID_WIDTH-1:0]                         in_id,
   output logic                                        in_ready,
   input  logic [1:0]                                  mode,
   input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0]   priorities,
   input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0]   budgets,
   input  logic [REGISTER_SIZE-1:0]                    replenish_period,
   output logic [DATA_SIZE-1:0]                        out_packet,
   output logic [QW-1:0]                               out_queue,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [NUMBER_OF_QUEUES-1:0]                 queue_full,
   output logic [NUMBER_OF_QUEUES-1:0]                 queue_empty,
   output logic                                        stall
);
   localparam int NQ = NUMBER_OF_QUEUES;
   localparam int AW = $clog2(QUEUE_LENGTH);
   localparam int CW = AW + 1;
   localparam int RS = REGISTER_SIZE;
   localparam int PS = PRIORITY_SIZE;

   logic [DATA_SIZE-1:0] mem_q [NQ][QUEUE_LENGTH];
   logic [AW-1:0]        rd_ptr_q [NQ], rd_ptr_d [NQ];
   logic [AW-1:0]        wr_ptr_q [NQ], wr_ptr_d [NQ];
   logic [CW-1:0]        cnt_q [NQ], cnt_d [NQ];
   logic [RS-1:0]        bud_q [NQ], bud_d [NQ];
   logic [RS-1:0]        rep_q, rep_d;
   logic                 load_q, load_d;
   logic [QW-1:0]        rr_q, rr_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_SIZE-1:0] out_packet_q, out_packet_d;
   logic [QW-1:0]        out_queue_q, out_queue_d;

   logic [QW-1:0]        in_sel_s, gnt_s, idx_s;
   logic [NQ-1:0]        full_s, empty_s, elig_s, pop_s, psh_s;
   logic                 push_s, slot_free_s, any_elig_s, grant_s, rep_ev_s, prio_mode_s;
   logic [PS-1:0]        best_s;
   logic                 unused_id_s;

   assign in_sel_s    = in_id[ID_OFFSET +: QW];
   assign unused_id_s = ^in_id;
   assign in_ready    = ~full_s[in_sel_s];
   assign push_s      = in_valid && in_ready;
   assign slot_free_s = !out_valid_q || out_ready;
   assign grant_s     = slot_free_s && any_elig_s;
   assign prio_mode_s = (mode == 2'd1) || (mode == 2'd2);
   assign rep_ev_s    = (replenish_period != '0) && (rep_q == replenish_period - RS'(1));

   // Status flags and eligibility come from the occupancy counts as they stood at the clock edge.
   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         full_s[i]  = (cnt_q[i] == CW'(QUEUE_LENGTH));
         empty_s[i] = (cnt_q[i] == '0);
         elig_s[i]  = !empty_s[i] && ((mode != 2'd2) || (bud_q[i] != '0) ||
                                      (budgets[i*RS +: RS] == '0));
      end
   end

   // Arbiter: strict priority with lowest-index tie-break, otherwise round-robin from rr_q.
   always_comb begin
      any_elig_s = 1'b0;
      best_s     = '0;
      gnt_s      = '0;
      idx_s      = '0;
      if (prio_mode_s) begin
         for (int i = 0; i < NQ; i++) begin
            if (elig_s[i] && (!any_elig_s || (priorities[i*PS +: PS] > best_s))) begin
               any_elig_s = 1'b1;
               best_s     = priorities[i*PS +: PS];
               gnt_s      = QW'(i);
            end
         end
      end else begin
         // Walk backwards so the nearest eligible queue at or after rr_q is the last one kept.
         for (int k = NQ - 1; k >= 0; k--) begin
            idx_s = rr_q + QW'(k);
            if (elig_s[idx_s]) begin
               any_elig_s = 1'b1;
               gnt_s      = idx_s;
            end
         end
      end
   end

   // Per-queue push/pop strobes.
   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         pop_s[i] = grant_s && (gnt_s == QW'(i));
         psh_s[i] = push_s && (in_sel_s == QW'(i));
      end
   end

   // Next state for the output slot, pointers, occupancy, budgets and replenish timer.
   always_comb begin
      rep_d        = ((replenish_period == '0) || (rep_q >= replenish_period - RS'(1))) ?
                     '0 : rep_q + RS'(1);
      load_d       = 1'b0;
      rr_d         = rr_q;
      out_valid_d  = out_valid_q;
      out_packet_d = out_packet_q;
      out_queue_d  = out_queue_q;
      if (grant_s) begin
         out_valid_d  = 1'b1;
         out_packet_d = mem_q[gnt_s][rd_ptr_q[gnt_s]];
         out_queue_d  = gnt_s;
         rr_d         = prio_mode_s ? rr_q : gnt_s + QW'(1);
      end else if (slot_free_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      for (int i = 0; i < NQ; i++) begin
         rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop_s[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + AW'(psh_s[i]);
         cnt_d[i]    = cnt_q[i] + CW'(psh_s[i]) - CW'(pop_s[i]);
         // A replenish in the same cycle as a grant restores the full budget without deduction.
         if (load_q || rep_ev_s) begin
            bud_d[i] = budgets[i*RS +: RS];
         end else if (pop_s[i] && (mode == 2'd2) && (bud_q[i] != '0)) begin
            bud_d[i] = bud_q[i] - RS'(1);
         end else begin
            bud_d[i] = bud_q[i];
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_packet_q <= '0;
         out_queue_q  <= '0;
         rr_q         <= '0;
         rep_q        <= '0;
         load_q       <= 1'b1;
         for (int i = 0; i < NQ; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            bud_q[i]    <= '0;
         end
      end else begin
         out_valid_q  <= out_valid_d;
         out_packet_q <= out_packet_d;
         out_queue_q  <= out_queue_d;
         rr_q         <= rr_d;
         rep_q        <= rep_d;
         load_q       <= load_d;
         for (int i = 0; i < NQ; i++) begin
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
            bud_q[i]    <= bud_d[i];
         end
      end
   end

   // Queue storage write port.
   always_ff @(posedge clock) begin
      if (reset && push_s) begin
         mem_q[in_sel_s][wr_ptr_q[in_sel_s]] <= in_packet;
      end
   end

   assign out_packet  = out_packet_q;
   assign out_queue   = out_queue_q;
   assign out_valid   = out_valid_q;
   assign queue_full  = full_s;
   assign queue_empty = empty_s;
   assign stall       = |full_s;
endmodule

// File: tb/tb_sched_queue_domain.sv
// Bench for sched_queue_domain: queue-based reference model checked every cycle,
// directed scenarios with hand-derived literal expectations, then randomized traffic.
module tb_sched_queue_domain;
   localparam int NQ = 4, DW = 64, QL = 16, IW = 16, IO = 5, PS = 4, RS = 32;

   logic clock = 1'b0, reset = 1'b0;
   logic [DW-1:0] in_packet = '0;
   logic in_valid = 1'b0;
   logic [IW-1:0] in_id = '0;
   logic in_ready;
   logic [1:0] mode = 2'd0;
   logic [NQ*PS-1:0] priorities = '0;
   logic [NQ*RS-1:0] budgets = '0;
   logic [RS-1:0] replenish_period = '0;
   logic [DW-1:0] out_packet;
   logic [1:0] out_queue;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [NQ-1:0] queue_full, queue_empty;
   logic stall;

   sched_queue_domain dut (
      .clock(clock), .reset(reset), .in_packet(in_packet), .in_valid(in_valid),
      .in_id(in_id), .in_ready(in_ready), .mode(mode), .priorities(priorities),
      .budgets(budgets), .replenish_period(replenish_period), .out_packet(out_packet),
      .out_queue(out_queue), .out_valid(out_valid), .out_ready(out_ready),
      .queue_full(queue_full), .queue_empty(queue_empty), .stall(stall)
   );

   always #5 clock = ~clock;

   int n_chk = 0, n_pass = 0, cyc = 0;
   int gq[$], gc[$];

   // Reference model state
   logic [DW-1:0] mq[NQ][$];
   bit            m_ov;
   logic [DW-1:0] m_op;
   int            m_oq, m_rr;
   logic [RS-1:0] m_bud[NQ];
   logic [RS-1:0] m_rep;
   bit            m_load;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
   endtask

   function automatic logic [PS-1:0] pri(int i);
      return priorities[i*PS +: PS];
   endfunction

   function automatic logic [RS-1:0] bud_in(int i);
      return budgets[i*RS +: RS];
   endfunction

   task automatic model_step();
      bit acc, ev, free;
      bit el[NQ];
      int t, win, j;
      if (!reset) begin
         for (int i = 0; i < NQ; i++) begin
            mq[i].delete();
            m_bud[i] = '0;
         end
         m_ov = 0; m_op = '0; m_oq = 0; m_rr = 0; m_rep = '0; m_load = 1;
         return;
      end
      t    = int'(in_id[IO +: 2]);
      acc  = in_valid && (mq[t].size() < QL);
      ev   = (replenish_period != 0) && (m_rep == replenish_period - 1);
      free = !m_ov || out_ready;
      win  = -1;
      for (int i = 0; i < NQ; i++)
         el[i] = (mq[i].size() > 0) && (mode != 2 || m_bud[i] != 0 || bud_in(i) == 0);
      if (mode == 1 || mode == 2) begin
         for (int i = 0; i < NQ; i++)
            if (el[i] && (win < 0 || pri(i) > pri(win))) win = i;
      end else begin
         for (int k = 0; k < NQ; k++) begin
            j = (m_rr + k) % NQ;
            if (win < 0 && el[j]) win = j;
         end
      end
      if (free && win >= 0) begin
         m_op = mq[win].pop_front();
         m_oq = win;
         m_ov = 1;
         if (!(mode == 1 || mode == 2)) m_rr = (win + 1) % NQ;
      end else if (free) begin
         m_ov = 0;
      end
      for (int i = 0; i < NQ; i++) begin
         if (m_load || ev) m_bud[i] = bud_in(i);
         else if (free && win == i && mode == 2 && m_bud[i] != 0) m_bud[i] = m_bud[i] - 1;
      end
      if (acc) mq[t].push_back(in_packet);
      m_load = 0;
      m_rep = (replenish_period == 0 || m_rep >= replenish_period - 1) ? '0 : m_rep + 1;
   endtask

   // One clock: check combinational ready, advance DUT and model, compare registered outputs.
   task automatic cycle();
      bit pre_free;
      logic [NQ-1:0] ef, ee;
      #1;
      if (reset) chk("in_ready", in_ready, mq[int'(in_id[IO +: 2])].size() < QL);
      pre_free = !out_valid || out_ready;
      @(posedge clock);
      model_step();
      #1;
      for (int i = 0; i < NQ; i++) begin
         ef[i] = (mq[i].size() == QL);
         ee[i] = (mq[i].size() == 0);
      end
      chk("out_valid", out_valid, m_ov);
      chk("out_packet", out_packet, m_op);
      chk("out_queue", out_queue, m_oq);
      chk("queue_full", queue_full, ef);
      chk("queue_empty", queue_empty, ee);
      chk("stall", stall, |ef);
      if (reset && pre_free && out_valid) begin
         gq.push_back(int'(out_queue));
         gc.push_back(cyc);
      end
      cyc++;
      @(negedge clock);
   endtask

   task automatic do_reset(int n);
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (n) cycle();
      reset = 1'b1;
   endtask

   task automatic push(int q, logic [DW-1:0] pkt);
      in_id = 16'($urandom);
      in_id[IO +: 2] = 2'(q);
      in_packet = pkt;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   int base, k, q2n;
   int exp_rr[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_fp[12]  = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
   int exp_b[6]    = '{19, 20, 21, 40, 41, 60};
   int q1c[$];

   initial begin
      // Reset and idle
      do_reset(3);
      repeat (2) cycle();
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_empty", queue_empty, 4'b1111);
      chk("reset_full", queue_full, 4'b0000);
      chk("reset_ready", in_ready, 1'b1);
      chk("reset_stall", stall, 1'b0);
      chk("reset_packet", out_packet, 64'h0);

      // Round-robin with a mid-stream hold
      mode = 2'd0; out_ready = 1'b0; gq.delete(); gc.delete();
      for (int n = 0; n < 8; n++) push(n % 4, 64'hA0 + 64'(n));
      out_ready = 1'b1; repeat (3) cycle();
      out_ready = 1'b0; repeat (5) cycle();
      chk("hold_pkt", out_packet, 64'hA3);
      chk("hold_valid", out_valid, 1'b1);
      out_ready = 1'b1; repeat (8) cycle();
      chk("rr_count", gq.size(), 8);
      for (int i = 0; i < 8; i++) chk("rr_seq", (gq.size() > i) ? gq[i] : -1, exp_rr[i]);

      // Fixed priority, q1/q2 tie
      do_reset(2);
      mode = 2'd1; priorities = {4'd2, 4'd9, 4'd9, 4'd1}; out_ready = 1'b0;
      gq.delete(); gc.delete();
      for (int n = 0; n < 12; n++) push(exp_fp[n], 64'hB0 + 64'(n));
      out_ready = 1'b1; repeat (14) cycle();
      chk("fp_count", gq.size(), 12);
      for (int i = 0; i < 12; i++) chk("fp_seq", (gq.size() > i) ? gq[i] : -1, exp_fp[i]);

      // Budget-regulated priority, replenish coincident with a grant
      mode = 2'd2; priorities = {4'd2, 4'd3, 4'd15, 4'd1};
      budgets = {32'd0, 32'd0, 32'd2, 32'd0}; replenish_period = 32'd20; out_ready = 1'b0;
      do_reset(2);
      gq.delete(); gc.delete();
      base = cyc;
      push(0, 64'hC0);
      for (int n = 0; n < 6; n++) push(1, 64'hC10 + 64'(n));
      for (int n = 0; n < 12; n++) push(2, 64'hC20 + 64'(n));
      out_ready = 1'b1;
      repeat (52) cycle();
      q1c.delete();
      for (int i = 0; i < gq.size(); i++) if (gq[i] == 1) q1c.push_back(gc[i] - base);
      chk("budget_count", q1c.size(), 6);
      for (int i = 0; i < 6; i++) chk("budget_cycle", (q1c.size() > i) ? q1c[i] : -1, exp_b[i]);

      // Fill queue 2 behind an occupied slot
      mode = 2'd0; budgets = '0; replenish_period = '0; out_ready = 1'b0;
      do_reset(2);
      gq.delete(); gc.delete();
      push(0, 64'hD0);
      for (int n = 0; n < 16; n++) push(2, 64'hD20 + 64'(n));
      chk("fill_full", queue_full, 4'b0100);
      chk("fill_empty", queue_empty, 4'b1011);
      chk("fill_stall", stall, 1'b1);
      in_id = 16'h0040; #1;
      chk("fill_ready_q2", in_ready, 1'b0);
      in_id = 16'h0000; #1;
      chk("fill_ready_q0", in_ready, 1'b1);
      push(2, 64'hDEAD);
      out_ready = 1'b1; repeat (20) cycle();
      q2n = 0;
      foreach (gq[i]) if (gq[i] == 2) q2n++;
      chk("fill_q2_grants", q2n, 16);
      chk("fill_total", gq.size(), 17);

      // Enqueue-to-output latency
      do_reset(2);
      out_ready = 1'b1; cycle();
      push(0, 64'hE0);
      chk("lat_early", out_valid, 1'b0);
      cycle();
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_queue", out_queue, 2'd0);
      chk("lat_packet", out_packet, 64'hE0);

      // Randomized traffic with policy changes and mid-traffic resets
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            mode = 2'($urandom_range(0, 3));
            priorities = 16'($urandom);
            for (int i = 0; i < NQ; i++) budgets[i*RS +: RS] = RS'($urandom_range(0, 3));
            replenish_period = RS'($urandom_range(0, 25));
         end
         if (n % 700 == 350) begin
            do_reset(3);
            chk("midreset_empty", queue_empty, 4'b1111);
            chk("midreset_valid", out_valid, 1'b0);
         end
         in_valid  = ($urandom_range(0, 99) < 60);
         in_id     = 16'($urandom);
         in_packet = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 99) < 55);
         cycle();
      end
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
